// File: rtl/ad_ip_jesd204_tpl_adc_sof_align_ctrl.sv
// ad_ip_jesd204_tpl_adc_sof_align_ctrl
// Frame-alignment controller for the TPL ADC deframer. Hunts for a stable
// start-of-frame pattern on the link beats, qualifies it over LOCK_COUNT
// matching SOF beats, then locks and publishes the octet rotation select.
// While locked, mismatching SOF beats are flagged and counted; UNLOCK_COUNT
// consecutive misses send the controller back to hunting.
//
// Optional feature: define AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN to add a
// watchdog that drops lock after TIMEOUT_BEATS valid beats without any SOF.
//
// Handshake: link_valid qualifies link_sof for the current cycle only; there
// is no back-pressure, every valid beat is consumed on the edge it is seen.

module ad_ip_jesd204_tpl_adc_sof_align_ctrl #(
    parameter int OCTETS_PER_BEAT = 4,
    parameter int SEL_WIDTH       = 2,
    parameter int LOCK_COUNT      = 4,
    parameter int UNLOCK_COUNT    = 2,
    parameter int TIMEOUT_BEATS   = 256
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       link_valid,
    input  logic [OCTETS_PER_BEAT-1:0] link_sof,
    input  logic                       align_enable,
    input  logic                       err_count_clear,
    output logic [SEL_WIDTH-1:0]       align_sel,
    output logic                       align_locked,
    output logic                       align_err,
    output logic [15:0]                err_count,
    output logic [1:0]                 state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_LIMIT   = 4'(LOCK_COUNT);
    localparam logic [3:0] UNLOCK_LIMIT = 4'(UNLOCK_COUNT);

    state_t                     state_q, state_d;
    logic [OCTETS_PER_BEAT-1:0] ref_q, ref_d;
    logic [3:0]                 match_cnt_q, match_cnt_d;
    logic [3:0]                 miss_cnt_q, miss_cnt_d;
    logic [SEL_WIDTH-1:0]       align_sel_q, align_sel_d;
    logic                       align_locked_q, align_locked_d;
    logic                       align_err_q, align_err_d;
    logic [15:0]                err_count_q, err_count_d;

    logic sof_beat;
    logic sof_match;

`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_BEATS);
    logic [15:0] wd_q, wd_d;
`else
    // Without the watchdog a missing SOF never ends lock; the parameter is inert.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_BEATS != 0);
`endif

    // Rotation select is the position of the earliest SOF octet in the beat.
    function automatic logic [SEL_WIDTH-1:0] lowest_set(input logic [OCTETS_PER_BEAT-1:0] v);
        logic [SEL_WIDTH-1:0] idx;
        idx = '0;
        for (int i = OCTETS_PER_BEAT - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL_WIDTH'(i);
        end
        return idx;
    endfunction

    assign sof_beat  = link_valid && (link_sof != '0);
    assign sof_match = (link_sof == ref_q);

    // Next-state logic: enable override first, then per-state hunt/verify/lock rules.
    always_comb begin
        state_d        = state_q;
        ref_d          = ref_q;
        match_cnt_d    = match_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        align_sel_d    = align_sel_q;
        align_locked_d = align_locked_q;
        align_err_d    = 1'b0;
`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
        wd_d           = '0;
`endif

        if (!align_enable) begin
            state_d        = ST_IDLE;
            align_locked_d = 1'b0;
            ref_d          = '0;
            match_cnt_d    = '0;
            miss_cnt_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d        = ST_HUNT;
                    align_locked_d = 1'b0;
                    ref_d          = '0;
                    match_cnt_d    = '0;
                    miss_cnt_d     = '0;
                end
                ST_HUNT: begin
                    if (sof_beat) begin
                        ref_d       = link_sof;
                        match_cnt_d = 4'd1;
                        state_d     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (sof_beat) begin
                        if (sof_match) begin
                            match_cnt_d = match_cnt_q + 4'd1;
                            if (match_cnt_q + 4'd1 == LOCK_LIMIT) begin
                                state_d        = ST_LOCKED;
                                align_sel_d    = lowest_set(link_sof);
                                align_locked_d = 1'b1;
                                miss_cnt_d     = '0;
                            end
                        end else begin
                            ref_d       = link_sof;
                            match_cnt_d = 4'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sof_beat) begin
                        if (sof_match) begin
                            miss_cnt_d = '0;
                        end else begin
                            align_err_d = 1'b1;
                            miss_cnt_d  = miss_cnt_q + 4'd1;
                            if (miss_cnt_q + 4'd1 == UNLOCK_LIMIT) begin
                                state_d        = ST_HUNT;
                                align_locked_d = 1'b0;
                                miss_cnt_d     = '0;
                                match_cnt_d    = '0;
                            end
                        end
                    end
`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
                    else if (link_valid) begin
                        // Valid beat with no SOF: advance the watchdog.
                        if (wd_q + 16'd1 == TIMEOUT_LIMIT) begin
                            align_err_d    = 1'b1;
                            state_d        = ST_HUNT;
                            align_locked_d = 1'b0;
                            miss_cnt_d     = '0;
                            match_cnt_d    = '0;
                        end else begin
                            wd_d = wd_q + 16'd1;
                        end
                    end else begin
                        wd_d = wd_q;
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Clear wins over a same-cycle increment; the count sticks at all-ones.
        if (err_count_clear) begin
            err_count_d = '0;
        end else if (align_err_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // All state and outputs registered; asynchronous reset drops any partial lock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            ref_q          <= '0;
            match_cnt_q    <= '0;
            miss_cnt_q     <= '0;
            align_sel_q    <= '0;
            align_locked_q <= 1'b0;
            align_err_q    <= 1'b0;
            err_count_q    <= '0;
`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
            wd_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ref_q          <= ref_d;
            match_cnt_q    <= match_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            align_sel_q    <= align_sel_d;
            align_locked_q <= align_locked_d;
            align_err_q    <= align_err_d;
            err_count_q    <= err_count_d;
`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
            wd_q           <= wd_d;
`endif
        end
    end

    assign align_sel    = align_sel_q;
    assign align_locked = align_locked_q;
    assign align_err    = align_err_q;
    assign err_count    = err_count_q;
    assign state        = state_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_sof_align_ctrl.sv
// Bench for ad_ip_jesd204_tpl_adc_sof_align_ctrl: constant vector table,
// directed corner sequences and randomized beats against a pattern-history
// reference model. Honours AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN.

module tb_ad_ip_jesd204_tpl_adc_sof_align_ctrl;

    localparam int OPB           = 4;
    localparam int LOCK_COUNT    = 4;
    localparam int UNLOCK_COUNT  = 2;
    localparam int TIMEOUT_BEATS = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic           link_valid = 1'b0;
    logic [OPB-1:0] link_sof = '0;
    logic           align_enable = 1'b0;
    logic           err_count_clear = 1'b0;
    logic [1:0]     align_sel;
    logic           align_locked;
    logic           align_err;
    logic [15:0]    err_count;
    logic [1:0]     state;

    ad_ip_jesd204_tpl_adc_sof_align_ctrl #(
        .OCTETS_PER_BEAT(OPB),
        .SEL_WIDTH(2),
        .LOCK_COUNT(LOCK_COUNT),
        .UNLOCK_COUNT(UNLOCK_COUNT),
        .TIMEOUT_BEATS(TIMEOUT_BEATS)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .link_valid(link_valid),
        .link_sof(link_sof),
        .align_enable(align_enable),
        .err_count_clear(err_count_clear),
        .align_sel(align_sel),
        .align_locked(align_locked),
        .align_err(align_err),
        .err_count(err_count),
        .state(state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Mode numbers are the status encoding: 0 idle, 1 hunt, 2 verify, 3 locked.
    int       m_mode;
    int       m_sel;
    int       m_err;
    int       m_cnt;
    int       m_miss;
    int       m_wd;
    logic [3:0] m_pat;
    logic [3:0] m_hist[$];   // SOF patterns seen since hunting began

    function automatic int lowest_index(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Length of the run of identical patterns at the end of the history.
    function automatic int tail_run();
        int n;
        n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] == m_hist[m_hist.size() - 1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_err = 0; m_cnt = 0; m_miss = 0; m_wd = 0; m_pat = '0;
        m_hist.delete();
    endtask

    task automatic model_step(input bit en, input bit v, input logic [3:0] sof, input bit clr);
        bit is_sof;
        bit err_now;
        is_sof  = v && (sof != 4'b0000);
        err_now = 1'b0;
        if (!en) begin
            m_mode = 0; m_miss = 0; m_wd = 0;
            m_hist.delete();
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_hist.delete();
        end else if (m_mode == 1 || m_mode == 2) begin
            if (is_sof) begin
                m_hist.push_back(sof);
                if (m_hist.size() > 16) void'(m_hist.pop_front());
                m_mode = 2;
                if (tail_run() >= LOCK_COUNT) begin
                    m_mode = 3; m_pat = sof; m_sel = lowest_index(sof); m_miss = 0; m_wd = 0;
                end
            end
        end else begin
            if (is_sof) begin
                m_wd = 0;
                if (sof == m_pat) m_miss = 0;
                else begin
                    err_now = 1'b1;
                    m_miss++;
                    if (m_miss >= UNLOCK_COUNT) begin
                        m_mode = 1; m_miss = 0; m_hist.delete();
                    end
                end
            end
`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
            else if (v) begin
                m_wd++;
                if (m_wd >= TIMEOUT_BEATS) begin
                    err_now = 1'b1; m_mode = 1; m_wd = 0; m_miss = 0; m_hist.delete();
                end
            end
`endif
        end
        if (clr) m_cnt = 0;
        else if (err_now && m_cnt < 65535) m_cnt++;
        m_err = err_now;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_state"},     int'(state),        m_mode);
        check({tag, "_locked"},    int'(align_locked), (m_mode == 3) ? 1 : 0);
        check({tag, "_sel"},       int'(align_sel),    m_sel);
        check({tag, "_err"},       int'(align_err),    m_err);
        check({tag, "_err_count"}, int'(err_count),    m_cnt);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input string tag, input bit en, input bit v, input logic [3:0] sof,
                        input bit clr);
        align_enable    = en;
        link_valid      = v;
        link_sof        = sof;
        err_count_clear = clr;
        @(posedge clk);
        model_step(en, v, sof, clr);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        align_enable = 1'b0; link_valid = 1'b0; link_sof = '0; err_count_clear = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic lock_on(input string tag, input logic [3:0] pat);
        step(tag, 1, 1, 4'b0000, 0);                  // IDLE -> HUNT
        for (int i = 0; i < LOCK_COUNT; i++) step(tag, 1, 1, pat, 0);
    endtask

    // ---------------- constant vector table ----------------
    typedef struct {
        bit         en;
        bit         v;
        logic [3:0] sof;
        bit         clr;
        int         exp_state;
        int         exp_locked;
        int         exp_sel;
        int         exp_err;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[14];

    logic [3:0] pats[6];

    initial begin
        vecs[0]  = '{1, 1, 4'b0100, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 4'b0100, 0, 2, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 4'b0100, 0, 2, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 4'b0100, 0, 2, 0, 0, 0, 0};
        vecs[4]  = '{1, 1, 4'b0100, 0, 3, 1, 2, 0, 0};
        vecs[5]  = '{1, 1, 4'b0100, 0, 3, 1, 2, 0, 0};
        vecs[6]  = '{1, 0, 4'b0010, 0, 3, 1, 2, 0, 0};
        vecs[7]  = '{1, 1, 4'b0001, 0, 3, 1, 2, 1, 1};
        vecs[8]  = '{1, 1, 4'b0000, 0, 3, 1, 2, 0, 1};
        vecs[9]  = '{1, 1, 4'b0100, 0, 3, 1, 2, 0, 1};
        vecs[10] = '{1, 1, 4'b0001, 0, 3, 1, 2, 1, 2};
        vecs[11] = '{1, 1, 4'b0010, 0, 1, 0, 2, 1, 3};
        vecs[12] = '{1, 1, 4'b1000, 1, 2, 0, 2, 0, 0};
        vecs[13] = '{0, 1, 4'b1000, 0, 0, 0, 2, 0, 0};

        pats[0] = 4'b0001; pats[1] = 4'b0010; pats[2] = 4'b0100;
        pats[3] = 4'b1000; pats[4] = 4'b0101; pats[5] = 4'b0000;

        // Reset state
        do_reset();
        #1;
        check("reset_state",  int'(state),        0);
        check("reset_locked", int'(align_locked), 0);
        check("reset_sel",    int'(align_sel),    0);
        check("reset_err",    int'(align_err),    0);
        check("reset_cnt",    int'(err_count),    0);

        // Table: lock on 0100, misses, recovery, unlock, clear, disable
        for (int i = 0; i < 14; i++) begin
            step("tbl_model", vecs[i].en, vecs[i].v, vecs[i].sof, vecs[i].clr);
            check($sformatf("tbl%0d_state", i),  int'(state),        vecs[i].exp_state);
            check($sformatf("tbl%0d_locked", i), int'(align_locked), vecs[i].exp_locked);
            check($sformatf("tbl%0d_sel", i),    int'(align_sel),    vecs[i].exp_sel);
            check($sformatf("tbl%0d_err", i),    int'(align_err),    vecs[i].exp_err);
            check($sformatf("tbl%0d_cnt", i),    int'(err_count),    vecs[i].exp_cnt);
        end

        // Re-qualify: two 0001 beats then four 0100 beats
        do_reset();
        step("requal", 1, 1, 4'b0000, 0);
        step("requal", 1, 1, 4'b0001, 0);
        step("requal", 1, 1, 4'b0001, 0);
        for (int i = 0; i < 3; i++) step("requal", 1, 1, 4'b0100, 0);
        check("requal_not_yet", int'(state), 2);
        step("requal", 1, 1, 4'b0100, 0);
        check("requal_locked", int'(state), 3);
        check("requal_sel", int'(align_sel), 2);

        // Loss: two consecutive misses on a 0001 lock
        do_reset();
        lock_on("loss", 4'b0001);
        step("loss", 1, 1, 4'b0010, 0);
        check("loss_err1", int'(align_err), 1);
        step("loss", 1, 1, 4'b0010, 0);
        check("loss_err2", int'(align_err), 1);
        check("loss_cnt", int'(err_count), 2);
        check("loss_state", int'(state), 1);
        check("loss_locked", int'(align_locked), 0);
        check("loss_sel", int'(align_sel), 0);

        // Single glitch keeps lock
        do_reset();
        lock_on("glitch", 4'b0001);
        step("glitch", 1, 1, 4'b1000, 0);
        step("glitch", 1, 1, 4'b0001, 0);
        check("glitch_cnt", int'(err_count), 1);
        check("glitch_state", int'(state), 3);

        // Saturation: preload the counter near the top, then keep erring
        force dut.err_count_q = 16'hFFFD;
        #1;
        release dut.err_count_q;
        m_cnt = 16'hFFFD;
        step("sat", 1, 1, 4'b0010, 0);
        step("sat", 1, 1, 4'b0001, 0);
        step("sat", 1, 1, 4'b0010, 0);
        check("sat_reach", int'(err_count), 16'hFFFF);
        step("sat", 1, 1, 4'b0001, 0);
        step("sat", 1, 1, 4'b0010, 0);
        check("sat_hold", int'(err_count), 16'hFFFF);
        step("sat", 1, 1, 4'b0001, 0);
        step("sat", 1, 1, 4'b0010, 1);
        check("clr_err", int'(align_err), 1);
        check("clr_cnt", int'(err_count), 0);

        // Disable while locked: IDLE, count kept
        step("dis", 1, 1, 4'b0001, 0);
        step("dis", 1, 1, 4'b1000, 0);
        step("dis", 0, 1, 4'b0001, 0);
        check("dis_state", int'(state), 0);
        check("dis_locked", int'(align_locked), 0);
        check("dis_cnt", int'(err_count), 1);

        // Asynchronous reset mid-VERIFY with non-zero sel and count
        do_reset();
        lock_on("arst", 4'b0100);
        step("arst", 1, 1, 4'b1000, 0);
        step("arst", 0, 0, 4'b0000, 0);
        step("arst", 1, 1, 4'b0000, 0);
        step("arst", 1, 1, 4'b0100, 0);
        step("arst", 1, 1, 4'b0100, 0);
        check("arst_pre_state", int'(state), 2);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_state",  int'(state),        0);
        check("arst_locked", int'(align_locked), 0);
        check("arst_sel",    int'(align_sel),    0);
        check("arst_err",    int'(align_err),    0);
        check("arst_cnt",    int'(err_count),    0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

`ifdef AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN
        // Watchdog: TIMEOUT_BEATS valid beats without SOF end the lock
        do_reset();
        lock_on("wd", 4'b0001);
        for (int i = 0; i < TIMEOUT_BEATS - 1; i++) step("wd", 1, 1, 4'b0000, 0);
        check("wd_before_state", int'(state), 3);
        check("wd_before_err", int'(align_err), 0);
        step("wd", 1, 1, 4'b0000, 0);
        check("wd_err", int'(align_err), 1);
        check("wd_state", int'(state), 1);
        check("wd_cnt", int'(err_count), 1);
`endif

        // Randomized beats against the reference model
        do_reset();
        begin
            int fav;
            fav = 2;
            for (int i = 0; i < 3000; i++) begin
                bit en, v, clr;
                logic [3:0] sof;
                if ($urandom_range(0, 39) == 0) fav = $urandom_range(0, 4);
                en  = ($urandom_range(0, 99) < 97);
                v   = ($urandom_range(0, 9) < 8);
                clr = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 9) < 8) sof = pats[fav];
                else sof = pats[$urandom_range(0, 5)];
                step("rand", en, v, sof, clr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ad_ip_jesd204_tpl_adc_sof_align_ctrl.md
Name: ad_ip_jesd204_tpl_adc_sof_align_ctrl

Overview:
- Frame-alignment controller for the TPL ADC deframer.
- Monitors the per-beat start-of-frame vector from the JESD204 link layer and hunts for a stable SOF pattern.
- Qualifies the pattern over several frames, then locks and publishes the octet rotation select used by the per-lane RX frame aligners.
- Flags and counts SOF misalignment while locked, and drops lock after repeated misses.

Parameters:
- OCTETS_PER_BEAT, 4, octets per link beat; width of link_sof. Must be 4 or 8.
- SEL_WIDTH, 2, width of align_sel; must equal log2(OCTETS_PER_BEAT).
- LOCK_COUNT, 4, consecutive matching SOF beats required to lock (2..15).
- UNLOCK_COUNT, 2, consecutive mismatching SOF beats in LOCKED that force re-hunt (1..15).
- TIMEOUT_BEATS, 256, valid beats without any SOF before a locked loss. Used only with the optional feature.

Ports:
- clk, input, 1, link clock (line-rate/40); everything is synchronous to its rising edge.
- resetn, input, 1, asynchronous active-low reset; deassertion is synchronous to clk externally.
- link_valid, input, 1, qualifies link_sof for the current beat.
- link_sof, input, OCTETS_PER_BEAT, SOF marker per octet position of the current beat.
- align_enable, input, 1, configuration enable from register map; 0 holds the block in IDLE.
- err_count_clear, input, 1, single-cycle pulse; clears err_count.
- align_sel, output, SEL_WIDTH, octet rotation select for the frame aligners; index of the lowest set bit of the locked pattern.
- align_locked, output, 1, high while in LOCKED.
- align_err, output, 1, one-cycle pulse per misaligned SOF beat while LOCKED.
- err_count, output, 16, saturating count of align_err pulses.
- state, output, 2, current FSM state for status readback: IDLE=0, HUNT=1, VERIFY=2, LOCKED=3.

Behaviour:
- Reset values (resetn=0, asynchronous): state IDLE, align_sel 0, align_locked 0, align_err 0, err_count 0. Internal reference pattern, match counter and miss counter are all 0.
- All outputs are registered. A beat sampled at edge n affects outputs after edge n (visible in cycle n+1).
- An "SOF beat" is a cycle with link_valid=1 and link_sof!=0. Non-SOF beats and invalid cycles never change state or counters (except the optional timeout).
- A "match" means link_sof equals the stored reference pattern. Multi-bit patterns are legal when F < OCTETS_PER_BEAT.
- IDLE:
  - align_locked=0 and counters cleared.
  - align_enable=1 -> HUNT.
- HUNT:
  - First SOF beat -> store pattern, match_cnt=1, go to VERIFY.
- VERIFY:
  - Match -> match_cnt+1. When match_cnt reaches LOCK_COUNT, go to LOCKED, load align_sel from the lowest set bit of the pattern, set align_locked=1, and clear miss_cnt.
  - Mismatch -> store the new pattern, match_cnt=1, stay in VERIFY.
- LOCKED:
  - Match -> miss_cnt=0.
  - Mismatch -> align_err=1 for one cycle, err_count+1, miss_cnt+1.
  - When miss_cnt reaches UNLOCK_COUNT, go to HUNT and set align_locked=0. align_sel keeps its last value until the next lock.
- align_enable=0 in any state -> IDLE on the next edge, overriding all other transitions. err_count and align_sel are not cleared.
- err_count saturates at 0xFFFF.
- err_count_clear has priority over a simultaneous increment; the result is 0.
- Reset asserted mid-operation returns all state asynchronously to the reset values. No partial lock is retained.

Optional Feature:
- Macro: AD_IP_JESD204_TPL_ADC_SOF_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts valid beats with link_sof==0 while LOCKED and resets on every SOF beat. Reaching TIMEOUT_BEATS produces one align_err pulse, increments err_count, and transitions to HUNT.
- Undefined: no watchdog logic; missing SOF never causes loss of lock.

Test Plan:
- Settings: OCTETS_PER_BEAT=4, LOCK_COUNT=4, UNLOCK_COUNT=2.
- Lock: enable=1, feed link_sof=4'b0100 every valid beat -> state goes HUNT, VERIFY, then LOCKED one cycle after the 4th matching beat; align_sel=2, align_locked=1, err_count=0.
- Re-qualify: in VERIFY after 2 beats of 4'b0001, send 4'b0100 -> match_cnt restarts. Lock occurs only after 4 consecutive 4'b0100 beats; align_sel=2.
- Loss: locked on 4'b0001, inject two consecutive SOF beats of 4'b0010 -> two align_err pulses, err_count=2, state HUNT, align_locked=0, align_sel still 0.
- Single glitch: locked, one 4'b1000 beat then a 4'b0001 beat -> err_count=1, stays LOCKED.
- Saturation/clear: preset err_count to 0xFFFF via errors -> stays 0xFFFF on further errors. err_count_clear on the same cycle as align_err -> err_count=0.
- Enable/reset: align_enable=0 while LOCKED -> IDLE next cycle, align_locked=0, err_count kept. resetn=0 asynchronously mid-VERIFY -> all outputs 0 immediately.
- Timeout (macro defined, TIMEOUT_BEATS=16): locked, then 16 valid beats with link_sof=0 -> one align_err pulse, state HUNT.
